// File: rtl/multi_channel_clock_divider.sv
// rtl/multi_channel_clock_divider.sv - NUM_CH programmable clock/enable dividers with staged, boundary-applied config
// Optional CLKDIV_SYNC_EN adds sync_start to phase-align all enabled channels.
module multi_channel_clock_divider #(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 16,
    parameter int DEFAULT_DIV = 40,
    localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              inp_clk,
    input  logic              inp_rst_n,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync_start,
`endif
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic              cfg_mode,
    input  logic [NUM_CH-1:0] ch_en,
    output logic [NUM_CH-1:0] out_clk,
    output logic [NUM_CH-1:0] out_tick
);

    localparam int CH_N = 1 << CH_W;
    localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

    logic              sync_w;
    logic [NUM_CH-1:0] pending;
    logic [CH_N-1:0]   pend_ext;

`ifdef CLKDIV_SYNC_EN
    assign sync_w = sync_start;
`else
    assign sync_w = 1'b0;
`endif

    // Unused channel codes read as permanently busy, so they are never accepted.
    always_comb begin
        pend_ext              = '1;
        pend_ext[NUM_CH-1:0]  = pending;
    end

    assign cfg_ready = ~pend_ext[cfg_ch] & ~sync_w;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] div;
        logic [CNT_W-1:0] stg_div;
        logic             mode;
        logic             stg_mode;
        logic             pend;
        logic             clk_q;
        logic             tick_q;
        logic             acc;

        assign acc        = cfg_valid & cfg_ready & (cfg_ch == CH_W'(i));
        assign pending[i] = pend;
        assign out_clk[i] = clk_q;
        assign out_tick[i] = tick_q;

        always_ff @(posedge inp_clk or negedge inp_rst_n) begin
            if (!inp_rst_n) begin
                cnt      <= RST_DIV;
                div      <= RST_DIV;
                stg_div  <= RST_DIV;
                mode     <= 1'b0;
                stg_mode <= 1'b0;
                pend     <= 1'b0;
                clk_q    <= 1'b0;
                tick_q   <= 1'b0;
            end else begin
                // acc implies pend==0, so it never collides with the clears below
                if (acc) begin
                    stg_div  <= cfg_div;
                    stg_mode <= cfg_mode;
                    pend     <= 1'b1;
                end
                if (!ch_en[i] || sync_w) begin
                    cnt    <= pend ? stg_div : div;
                    clk_q  <= 1'b0;
                    tick_q <= 1'b0;
                    if (pend) begin
                        div  <= stg_div;
                        mode <= stg_mode;
                        pend <= 1'b0;
                    end
                end else if (cnt == '0) begin
                    tick_q <= 1'b1;
                    if (pend) begin
                        cnt   <= stg_div;
                        div   <= stg_div;
                        mode  <= stg_mode;
                        pend  <= 1'b0;
                        clk_q <= (stg_mode != mode) ? 1'b0 : (mode ? 1'b1 : ~clk_q);
                    end else begin
                        cnt   <= div;
                        clk_q <= mode ? 1'b1 : ~clk_q;
                    end
                end else begin
                    cnt    <= cnt - 1'b1;
                    tick_q <= 1'b0;
                    if (mode) clk_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_channel_clock_divider.sv
// tb/tb_multi_channel_clock_divider.sv - directed table-driven bench for multi_channel_clock_divider
module tb_multi_channel_clock_divider;

    logic        inp_clk = 1'b0;
    logic        inp_rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic        cfg_mode;
    logic [3:0]  ch_en;
    logic [3:0]  out_clk;
    logic [3:0]  out_tick;
`ifdef CLKDIV_SYNC_EN
    logic        sync_start;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    multi_channel_clock_divider #(.NUM_CH(4), .CNT_W(16), .DEFAULT_DIV(40)) dut (
        .inp_clk   (inp_clk),
        .inp_rst_n (inp_rst_n),
`ifdef CLKDIV_SYNC_EN
        .sync_start(sync_start),
`endif
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .cfg_mode  (cfg_mode),
        .ch_en     (ch_en),
        .out_clk   (out_clk),
        .out_tick  (out_tick)
    );

    always #5 inp_clk = ~inp_clk;

    typedef struct {
        int ch;
        int div;
        bit mode;
        int exp_first;
        int exp_gap;
        bit exp_clk1;
        bit exp_clk2;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge inp_clk);
        #2;
    endtask

    task automatic do_reset();
        inp_rst_n = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd0;
        cfg_mode  = 1'b0;
        ch_en     = 4'b0000;
`ifdef CLKDIV_SYNC_EN
        sync_start = 1'b0;
`endif
        tick();
        tick();
        inp_rst_n = 1'b1;
    endtask

    // Steps until out_tick[ch] is seen; n is the number of edges taken.
    task automatic wait_ev(input int ch, input int max_n, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!out_tick[ch] && n < max_n);
    endtask

    // Presents a config and holds it until accepted; returns with cfg_valid low.
    task automatic cfg(input int ch, input int div, input bit mode, output int waited);
        cfg_valid = 1'b1;
        cfg_ch    = 2'(ch);
        cfg_div   = 16'(div);
        cfg_mode  = mode;
        waited    = 0;
        #1;
        while (!cfg_ready && waited < 200) begin
            tick();
            waited++;
            #1;
        end
        tick();
        cfg_valid = 1'b0;
    endtask

    initial begin
        int n;
        int w;

        vecs[0] = '{ch: 0, div: 5, mode: 1'b0, exp_first: 6, exp_gap: 6, exp_clk1: 1'b1, exp_clk2: 1'b0};
        vecs[1] = '{ch: 1, div: 3, mode: 1'b1, exp_first: 4, exp_gap: 4, exp_clk1: 1'b1, exp_clk2: 1'b1};
        vecs[2] = '{ch: 3, div: 0, mode: 1'b0, exp_first: 1, exp_gap: 1, exp_clk1: 1'b1, exp_clk2: 1'b0};
        vecs[3] = '{ch: 2, div: 0, mode: 1'b1, exp_first: 1, exp_gap: 1, exp_clk1: 1'b1, exp_clk2: 1'b1};
        vecs[4] = '{ch: 2, div: 1, mode: 1'b0, exp_first: 2, exp_gap: 2, exp_clk1: 1'b1, exp_clk2: 1'b0};

        // Reset state and default divisor on ch0
        do_reset();
        check("rst_out_clk", out_clk, 0);
        check("rst_out_tick", out_tick, 0);
        #1;
        check("rst_cfg_ready", cfg_ready, 1);
        ch_en = 4'b0001;
        wait_ev(0, 100, n);
        check("default_first", n, 41);
        check("default_clk1", out_clk[0], 1);
        tick();
        check("default_tick_width", out_tick[0], 0);
        wait_ev(0, 100, n);
        check("default_gap", n, 40);
        check("default_clk2", out_clk[0], 0);

        // Table: configure while disabled, then enable
        foreach (vecs[k]) begin
            do_reset();
            cfg(vecs[k].ch, vecs[k].div, vecs[k].mode, w);
            tick();
            ch_en = 4'(1 << vecs[k].ch);
            wait_ev(vecs[k].ch, 100, n);
            check($sformatf("vec%0d_first", k), n, vecs[k].exp_first);
            check($sformatf("vec%0d_clk1", k), out_clk[vecs[k].ch], vecs[k].exp_clk1);
            wait_ev(vecs[k].ch, 100, n);
            check($sformatf("vec%0d_gap", k), n, vecs[k].exp_gap);
            check($sformatf("vec%0d_clk2", k), out_clk[vecs[k].ch], vecs[k].exp_clk2);
        end

        // Pulse config on a running channel
        do_reset();
        ch_en = 4'b1111;
        cfg(1, 3, 1'b1, w);
        cfg_ch = 2'd1;
        #1;
        check("sw_ready_low", cfg_ready, 0);
        wait_ev(1, 100, n);
        check("sw_event_at", n, 40);
        check("sw_clk_zero", out_clk[1], 0);
        check("sw_ready_back", cfg_ready, 1);
        wait_ev(1, 100, n);
        check("pulse_gap", n, 4);
        check("pulse_high", out_clk[1], 1);
        tick();
        check("pulse_low_after", out_clk[1], 0);

        // Accept coincident with event on ch2
        do_reset();
        ch_en = 4'b0100;
        repeat (40) tick();
        cfg_valid = 1'b1;
        cfg_ch    = 2'd2;
        cfg_div   = 16'd5;
        cfg_mode  = 1'b0;
        #1;
        check("coin_ready_pre", cfg_ready, 1);
        tick();
        cfg_valid = 1'b0;
        check("coin_tick", out_tick[2], 1);
        check("coin_clk", out_clk[2], 1);
        #1;
        check("coin_pending", cfg_ready, 0);
        wait_ev(2, 100, n);
        check("coin_old_period", n, 41);
        check("coin_apply_clk", out_clk[2], 0);
        wait_ev(2, 100, n);
        check("coin_new_period", n, 6);

        // Second config while pending, then disable with pending
        do_reset();
        ch_en = 4'b0001;
        cfg(0, 7, 1'b0, w);
        cfg_valid = 1'b1;
        cfg_ch    = 2'd0;
        cfg_div   = 16'd2;
        #1;
        check("hold_ready_low", cfg_ready, 0);
        cfg(0, 2, 1'b0, w);
        check("hold_wait", w, 40);
        #1;
        check("hold_accepted", cfg_ready, 0);
        wait_ev(0, 100, n);
        check("hold_div7_period", n, 7);
        wait_ev(0, 100, n);
        check("hold_div2_period", n, 3);
        cfg(0, 5, 1'b0, w);
        ch_en = 4'b0000;
        tick();
        cfg_ch = 2'd0;
        #1;
        check("dis_ready", cfg_ready, 1);
        check("dis_clk", out_clk[0], 0);
        ch_en = 4'b0001;
        wait_ev(0, 100, n);
        check("reen_first", n, 6);
        check("reen_clk", out_clk[0], 1);

        // Asynchronous reset mid-period with a pending config
        do_reset();
        ch_en = 4'b1111;
        repeat (45) tick();
        check("pre_rst_clk", out_clk, 4'b1111);
        cfg(0, 3, 1'b1, w);
        inp_rst_n = 1'b0;
        #1;
        check("async_rst_clk", out_clk, 0);
        check("async_rst_tick", out_tick, 0);
        check("async_rst_ready", cfg_ready, 1);
        tick();
        inp_rst_n = 1'b1;
        wait_ev(0, 100, n);
        check("post_rst_first", n, 41);
        check("post_rst_clk1", out_clk[0], 1);
        wait_ev(0, 100, n);
        check("post_rst_gap", n, 41);
        check("post_rst_clk2", out_clk[0], 0);

`ifdef CLKDIV_SYNC_EN
        // Phase alignment via sync_start
        do_reset();
        cfg(0, 2, 1'b0, w);
        cfg(1, 5, 1'b0, w);
        tick();
        ch_en = 4'b0011;
        repeat (5) tick();
        sync_start = 1'b1;
        #1;
        check("sync_ready_low", cfg_ready, 0);
        tick();
        sync_start = 1'b0;
        check("sync_clk_zero", out_clk[1:0], 0);
        wait_ev(0, 100, n);
        check("sync_ch0_first", n, 3);
        wait_ev(0, 100, n);
        check("sync_ch0_second", n, 3);
        check("sync_ch1_coincident", out_tick[1], 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
